// File: rtl/mac_cfg_master.sv
// -----------------------------------------------------------------------------
// mac_cfg_master
// Initiator for the hwpe_ctrl peripheral protocol. It programs and runs one
// MAC job on the MAC control slave. The sequence per job is:
//   1. Acquire a context (retry while the slave is busy).
//   2. Write the job registers.
//   3. Trigger the job.
//   4. Poll STATUS until idle, or until the poll budget runs out.
//   5. Read the engine counter from debug space.
//   6. Return a completion record.
//
// Ports
//   clk_i, rst_i           clock, synchronous active-high reset
//   job_valid_i/ready_o    job descriptor handshake
//   job_regs_i             N_JOB_REGS x 32b register image, sampled on accept
//   done_valid_o/ready_i   completion record handshake
//   done_ctx_o             context id granted by ACQUIRE
//   done_cnt_o             engine counter (0 on timeout)
//   done_err_o             STATUS poll timeout flag
//   periph_*               hwpe periph request/response channel
// -----------------------------------------------------------------------------
module mac_cfg_master #(
    parameter int unsigned N_JOB_REGS   = 8,
    parameter logic [31:0] BASE_ADDR    = 32'h0,
    parameter logic [31:0] JOB_OFFS     = 32'h40,
    parameter int unsigned ID_WIDTH     = 10,
    parameter int unsigned ID           = 10,
    parameter int unsigned RETRY_GAP    = 4,
    parameter int unsigned POLL_TIMEOUT = 65535
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    job_valid_i,
    output logic                    job_ready_o,
    input  logic [N_JOB_REGS*32-1:0] job_regs_i,
    output logic                    done_valid_o,
    input  logic                    done_ready_i,
    output logic [7:0]              done_ctx_o,
    output logic [31:0]             done_cnt_o,
    output logic                    done_err_o,
    output logic                    periph_req_o,
    input  logic                    periph_gnt_i,
    output logic [31:0]             periph_add_o,
    output logic                    periph_wen_o,
    output logic [3:0]              periph_be_o,
    output logic [31:0]             periph_data_o,
    output logic [ID_WIDTH-1:0]     periph_id_o,
    input  logic [31:0]             periph_r_data_i,
    input  logic                    periph_r_valid_i,
    input  logic [ID_WIDTH-1:0]     periph_r_id_i
);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_ACQ      = 4'd1;
    localparam logic [3:0] S_ACQ_GAP  = 4'd2;
    localparam logic [3:0] S_WR       = 4'd3;
    localparam logic [3:0] S_TRIG     = 4'd4;
    localparam logic [3:0] S_POLL     = 4'd5;
    localparam logic [3:0] S_POLL_GAP = 4'd6;
    localparam logic [3:0] S_DBG      = 4'd7;
    localparam logic [3:0] S_DONE     = 4'd8;

    localparam logic [4:0]  LAST_IDX  = 5'(N_JOB_REGS - 1);
    localparam logic [15:0] GAP_LAST  = 16'(RETRY_GAP - 1);
    localparam logic [15:0] POLL_LAST = 16'(POLL_TIMEOUT);

    logic [3:0]  state_reg,    state_next;
    logic        wait_rsp_reg, wait_rsp_next;
    logic [4:0]  wr_idx_reg,   wr_idx_next;
    logic [15:0] gap_cnt_reg,  gap_cnt_next;
    logic [15:0] poll_cnt_reg, poll_cnt_next;
    logic [7:0]  ctx_reg,      ctx_next;
    logic [31:0] cnt_reg,      cnt_next;
    logic        err_reg,      err_next;

    logic [31:0] job_regs_reg [N_JOB_REGS];

    logic        accept;
    logic        rsp;
    logic        req_state;
    logic        shift_en;
    logic [15:0] poll_inc;

    // The response id carries no information for a single-outstanding master.
    logic unused_rid;
    assign unused_rid = ^periph_r_id_i;

    assign job_ready_o = (state_reg == S_IDLE) && !rst_i;
    assign accept      = job_valid_i && job_ready_o;

    assign req_state = (state_reg == S_ACQ)  || (state_reg == S_WR) ||
                       (state_reg == S_TRIG) || (state_reg == S_POLL) ||
                       (state_reg == S_DBG);

    // The request drops in the reset cycle itself, not one cycle later.
    assign periph_req_o = req_state && !wait_rsp_reg && !rst_i;

    // A response only counts while a granted transaction is open.
    // This filters out a stray r_valid that arrives after a reset.
    assign rsp      = wait_rsp_reg && periph_r_valid_i;
    assign shift_en = (state_reg == S_WR) && rsp;
    assign poll_inc = poll_cnt_reg + 16'd1;

    assign periph_be_o  = 4'hF;
    assign periph_id_o  = ID_WIDTH'(ID);
    assign done_valid_o = (state_reg == S_DONE);
    assign done_ctx_o   = ctx_reg;
    assign done_cnt_o   = cnt_reg;
    assign done_err_o   = err_reg;

    // Job register image as a shift register. Slot 0 always holds the
    // next word to write, so the write data needs no variable index.
    genvar gi;
    generate
        for (gi = 0; gi < N_JOB_REGS; gi++) begin : g_job
            if (gi < N_JOB_REGS - 1) begin : g_mid
                always_ff @(posedge clk_i) begin
                    if (rst_i) begin
                        job_regs_reg[gi] <= '0;
                    end else if (accept) begin
                        job_regs_reg[gi] <= job_regs_i[gi*32 +: 32];
                    end else if (shift_en) begin
                        job_regs_reg[gi] <= job_regs_reg[gi+1];
                    end
                end
            end else begin : g_last
                always_ff @(posedge clk_i) begin
                    if (rst_i) begin
                        job_regs_reg[gi] <= '0;
                    end else if (accept) begin
                        job_regs_reg[gi] <= job_regs_i[gi*32 +: 32];
                    end else if (shift_en) begin
                        job_regs_reg[gi] <= '0;
                    end
                end
            end
        end
    endgenerate

    // Request payload is a pure function of state.
    // It therefore stays stable while the request waits for its grant.
    always_comb begin
        periph_add_o  = '0;
        periph_wen_o  = 1'b1;
        periph_data_o = '0;
        case (state_reg)
            S_ACQ:  periph_add_o = BASE_ADDR + 32'h4;
            S_WR: begin
                periph_add_o  = BASE_ADDR + JOB_OFFS + {25'd0, wr_idx_reg, 2'b00};
                periph_wen_o  = 1'b0;
                periph_data_o = job_regs_reg[0];
            end
            S_TRIG: begin
                periph_add_o = BASE_ADDR;
                periph_wen_o = 1'b0;
            end
            S_POLL: periph_add_o = BASE_ADDR + 32'hC;
            S_DBG:  periph_add_o = BASE_ADDR + 32'h1004;
            default: ;
        endcase
    end

    always_comb begin
        state_next    = state_reg;
        wait_rsp_next = wait_rsp_reg;
        wr_idx_next   = wr_idx_reg;
        gap_cnt_next  = gap_cnt_reg;
        poll_cnt_next = poll_cnt_reg;
        ctx_next      = ctx_reg;
        cnt_next      = cnt_reg;
        err_next      = err_reg;

        if (periph_req_o && periph_gnt_i) begin
            wait_rsp_next = 1'b1;
        end
        if (rsp) begin
            wait_rsp_next = 1'b0;
        end

        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    state_next    = S_ACQ;
                    wait_rsp_next = 1'b0;
                    wr_idx_next   = '0;
                    gap_cnt_next  = '0;
                    poll_cnt_next = '0;
                    err_next      = 1'b0;
                end
            end
            S_ACQ: begin
                if (rsp) begin
                    if (periph_r_data_i[31]) begin
                        state_next   = S_ACQ_GAP;
                        gap_cnt_next = '0;
                    end else begin
                        state_next  = S_WR;
                        ctx_next    = periph_r_data_i[7:0];
                        wr_idx_next = '0;
                    end
                end
            end
            S_ACQ_GAP: begin
                if (gap_cnt_reg == GAP_LAST) begin
                    state_next = S_ACQ;
                end else begin
                    gap_cnt_next = gap_cnt_reg + 16'd1;
                end
            end
            S_WR: begin
                if (rsp) begin
                    if (wr_idx_reg == LAST_IDX) begin
                        state_next = S_TRIG;
                    end else begin
                        wr_idx_next = wr_idx_reg + 5'd1;
                    end
                end
            end
            S_TRIG: begin
                if (rsp) begin
                    state_next = S_POLL;
                end
            end
            S_POLL: begin
                if (rsp) begin
                    poll_cnt_next = poll_inc;
                    if (!periph_r_data_i[0]) begin
                        state_next = S_DBG;
                    end else if (poll_inc == POLL_LAST) begin
                        // Budget exhausted while still busy: report without a DBG read.
                        state_next = S_DONE;
                        err_next   = 1'b1;
                        cnt_next   = '0;
                    end else begin
                        state_next   = S_POLL_GAP;
                        gap_cnt_next = '0;
                    end
                end
            end
            S_POLL_GAP: begin
                if (gap_cnt_reg == GAP_LAST) begin
                    state_next = S_POLL;
                end else begin
                    gap_cnt_next = gap_cnt_reg + 16'd1;
                end
            end
            S_DBG: begin
                if (rsp) begin
                    state_next = S_DONE;
                    cnt_next   = periph_r_data_i;
                end
            end
            S_DONE: begin
                if (done_ready_i) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg    <= S_IDLE;
            wait_rsp_reg <= 1'b0;
            wr_idx_reg   <= '0;
            gap_cnt_reg  <= '0;
            poll_cnt_reg <= '0;
            ctx_reg      <= '0;
            cnt_reg      <= '0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_rsp_reg <= wait_rsp_next;
            wr_idx_reg   <= wr_idx_next;
            gap_cnt_reg  <= gap_cnt_next;
            poll_cnt_reg <= poll_cnt_next;
            ctx_reg      <= ctx_next;
            cnt_reg      <= cnt_next;
            err_reg      <= err_next;
        end
    end

endmodule

// File: tb/tb_mac_cfg_master.sv
// -----------------------------------------------------------------------------
// tb_mac_cfg_master
// Bench for mac_cfg_master with a behavioural periph slave.
// Each scenario pushes its expected transaction list, with canned read data,
// into a queue. The slave pops one entry per grant and compares it there.
// Scenario tasks check the completion records and the slave's log.
// -----------------------------------------------------------------------------
module tb_mac_cfg_master;

    localparam int N  = 8;
    localparam int RG = 4;
    localparam int TO = 3;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            job_valid_i;
    logic            job_ready_o;
    logic [N*32-1:0] job_regs_i;
    logic            done_valid_o;
    logic            done_ready_i;
    logic [7:0]      done_ctx_o;
    logic [31:0]     done_cnt_o;
    logic            done_err_o;
    logic            periph_req_o;
    logic            periph_gnt_i;
    logic [31:0]     periph_add_o;
    logic            periph_wen_o;
    logic [3:0]      periph_be_o;
    logic [31:0]     periph_data_o;
    logic [9:0]      periph_id_o;
    logic [31:0]     periph_r_data_i;
    logic            periph_r_valid_i;
    logic [9:0]      periph_r_id_i;

    always #5 clk_i = ~clk_i;

    mac_cfg_master #(
        .N_JOB_REGS   (N),
        .BASE_ADDR    (32'h0),
        .JOB_OFFS     (32'h40),
        .ID_WIDTH     (10),
        .ID           (10),
        .RETRY_GAP    (RG),
        .POLL_TIMEOUT (TO)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .job_valid_i      (job_valid_i),
        .job_ready_o      (job_ready_o),
        .job_regs_i       (job_regs_i),
        .done_valid_o     (done_valid_o),
        .done_ready_i     (done_ready_i),
        .done_ctx_o       (done_ctx_o),
        .done_cnt_o       (done_cnt_o),
        .done_err_o       (done_err_o),
        .periph_req_o     (periph_req_o),
        .periph_gnt_i     (periph_gnt_i),
        .periph_add_o     (periph_add_o),
        .periph_wen_o     (periph_wen_o),
        .periph_be_o      (periph_be_o),
        .periph_data_o    (periph_data_o),
        .periph_id_o      (periph_id_o),
        .periph_r_data_i  (periph_r_data_i),
        .periph_r_valid_i (periph_r_valid_i),
        .periph_r_id_i    (periph_r_id_i)
    );

    typedef struct {
        logic [31:0] addr;
        logic        wen;
        logic [31:0] data;
        logic [31:0] rsp;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          gap;   // cycles from the previous r_valid to the first sight of this req
        int          hold;  // cycles req was seen before the grant
    } log_t;

    exp_t exp_q[$];
    log_t log_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Slave state.
    logic        pending   = 1'b0;
    logic [31:0] pend_data = '0;
    logic        in_req    = 1'b0;
    int          hold      = 0;
    int          req_start = 0;
    int          last_rv   = 0;
    logic [31:0] cap_add   = '0;
    logic [31:0] cap_data  = '0;
    logic        cap_wen   = 1'b1;
    logic [31:0] dly_addr  = 32'hFFFF_FFFF;
    int          dly_cycles = 0;

    // Periph slave. It drives on the falling edge and samples the DUT there.
    // Default behaviour: grant in the same cycle, r_valid one cycle after the grant.
    initial begin
        exp_t e;
        periph_gnt_i     = 1'b0;
        periph_r_valid_i = 1'b0;
        periph_r_data_i  = '0;
        periph_r_id_i    = 10'd10;
        forever begin
            @(negedge clk_i);
            cyc++;
            periph_gnt_i     = 1'b0;
            periph_r_valid_i = 1'b0;
            if (rst_i) begin
                pending = 1'b0;
                in_req  = 1'b0;
            end else begin
                if (pending) begin
                    periph_r_valid_i = 1'b1;
                    periph_r_data_i  = pend_data;
                    pending          = 1'b0;
                    last_rv          = cyc;
                end
                if (periph_req_o) begin
                    if (!in_req) begin
                        in_req    = 1'b1;
                        hold      = 1;
                        req_start = cyc;
                        cap_add   = periph_add_o;
                        cap_data  = periph_data_o;
                        cap_wen   = periph_wen_o;
                    end else begin
                        hold++;
                        n_checks++;
                        if (periph_add_o !== cap_add || periph_data_o !== cap_data ||
                            periph_wen_o !== cap_wen) begin
                            n_fail++;
                            $display("FAIL hold_stable: got add=%h wen=%b data=%h, required add=%h wen=%b data=%h",
                                     periph_add_o, periph_wen_o, periph_data_o, cap_add, cap_wen, cap_data);
                        end
                    end
                    if (hold > ((periph_add_o == dly_addr) ? dly_cycles : 0)) begin
                        periph_gnt_i = 1'b1;
                        in_req       = 1'b0;
                        pending      = 1'b1;
                        pend_data    = '0;
                        n_checks++;
                        if (periph_be_o !== 4'hF || periph_id_o !== 10'd10) begin
                            n_fail++;
                            $display("FAIL be_id: got be=%h id=%0d, required be=f id=10",
                                     periph_be_o, periph_id_o);
                        end
                        n_checks++;
                        if (exp_q.size() == 0) begin
                            n_fail++;
                            $display("FAIL unexpected_txn: got add=%h wen=%b data=%h, required no transaction",
                                     periph_add_o, periph_wen_o, periph_data_o);
                        end else begin
                            e = exp_q.pop_front();
                            pend_data = e.rsp;
                            if (periph_add_o !== e.addr || periph_wen_o !== e.wen ||
                                (!e.wen && periph_data_o !== e.data)) begin
                                n_fail++;
                                $display("FAIL txn: got add=%h wen=%b data=%h, required add=%h wen=%b data=%h",
                                         periph_add_o, periph_wen_o, periph_data_o, e.addr, e.wen, e.data);
                            end
                        end
                        log_q.push_back('{periph_add_o, req_start - last_rv, hold});
                    end
                end
            end
        end
    end

    task automatic push_rd(input logic [31:0] a, input logic [31:0] r);
        exp_t e;
        e.addr = a; e.wen = 1'b1; e.data = '0; e.rsp = r;
        exp_q.push_back(e);
    endtask

    task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        e.addr = a; e.wen = 1'b0; e.data = d; e.rsp = '0;
        exp_q.push_back(e);
    endtask

    // Pushes the N job-register writes followed by the trigger write.
    task automatic push_writes_trig(input logic [N*32-1:0] regs);
        for (int k = 0; k < N; k++) begin
            push_wr(32'h40 + 32'(4 * k), regs[k*32 +: 32]);
        end
        push_wr(32'h0, 32'h0);
    endtask

    function automatic logic [N*32-1:0] rand_regs();
        logic [N*32-1:0] r;
        for (int k = 0; k < N; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic int count_addr(input logic [31:0] a);
        int c = 0;
        foreach (log_q[i]) if (log_q[i].addr == a) c++;
        return c;
    endfunction

    task automatic start_job(input logic [N*32-1:0] regs);
        @(negedge clk_i);
        job_regs_i  = regs;
        job_valid_i = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (job_ready_o) begin
                @(posedge clk_i);
                #1;
                job_valid_i = 1'b0;
                return;
            end
            @(negedge clk_i);
        end
        job_valid_i = 1'b0;
        n_checks++;
        n_fail++;
        $display("FAIL start_job: job_ready_o=0 for 200 cycles, required 1");
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_i);
            if (done_valid_o) begin
                ok = 1'b1;
                return;
            end
        end
        n_checks++;
        n_fail++;
        $display("FAIL wait_done: done_valid_o=0 after 3000 cycles, required 1");
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) @(negedge clk_i);
        n_checks++;
        if (job_ready_o !== 1'b0 || periph_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_during: got job_ready=%b req=%b, required 0 0", job_ready_o, periph_req_o);
        end
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        n_checks++;
        if (job_ready_o !== 1'b1 || done_valid_o !== 1'b0 || periph_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got job_ready=%b done_valid=%b req=%b, required 1 0 0",
                     job_ready_o, done_valid_o, periph_req_o);
        end
        n_checks++;
        if (done_ctx_o !== 8'h0 || done_cnt_o !== 32'h0 || done_err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_done_fields: got ctx=%h cnt=%h err=%b, required 0 0 0",
                     done_ctx_o, done_cnt_o, done_err_o);
        end
        n_checks++;
        if (periph_add_o !== 32'h0 || periph_data_o !== 32'h0 || periph_wen_o !== 1'b1 ||
            periph_be_o !== 4'hF || periph_id_o !== 10'd10) begin
            n_fail++;
            $display("FAIL reset_periph: got add=%h data=%h wen=%b be=%h id=%0d, required 0 0 1 f 10",
                     periph_add_o, periph_data_o, periph_wen_o, periph_be_o, periph_id_o);
        end
    endtask

    task automatic test_happy();
        logic [N*32-1:0] regs;
        bit ok;
        regs = rand_regs();
        log_q.delete();
        push_rd(32'h4, 32'h0);
        push_writes_trig(regs);
        push_rd(32'hC, 32'h1);
        push_rd(32'hC, 32'h1);
        push_rd(32'hC, 32'h0);
        push_rd(32'h1004, 32'h20);
        start_job(regs);
        @(negedge clk_i);
        n_checks++;
        if (periph_req_o !== 1'b1 || periph_add_o !== 32'h4 || periph_wen_o !== 1'b1) begin
            n_fail++;
            $display("FAIL happy_req_after_accept: got req=%b add=%h wen=%b, required 1 00000004 1",
                     periph_req_o, periph_add_o, periph_wen_o);
        end
        wait_done(ok);
        if (ok) begin
            n_checks++;
            if (done_ctx_o !== 8'h0 || done_cnt_o !== 32'h20 || done_err_o !== 1'b0) begin
                n_fail++;
                $display("FAIL happy_done: got ctx=%h cnt=%h err=%b, required 00 00000020 0",
                         done_ctx_o, done_cnt_o, done_err_o);
            end
        end
        @(negedge clk_i);
        n_checks++;
        if (done_valid_o !== 1'b0 || job_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL happy_handshake: got done_valid=%b job_ready=%b, required 0 1",
                     done_valid_o, job_ready_o);
        end
        n_checks++;
        if (exp_q.size() != 0 || log_q.size() != 14 || count_addr(32'hC) != 3) begin
            n_fail++;
            $display("FAIL happy_count: got left=%0d txns=%0d status=%0d, required 0 14 3",
                     exp_q.size(), log_q.size(), count_addr(32'hC));
        end
        if (log_q.size() == 14) begin
            for (int k = 0; k < N; k++) begin
                n_checks++;
                if (log_q[1+k].addr !== 32'h40 + 32'(4 * k)) begin
                    n_fail++;
                    $display("FAIL happy_wr_order: got add=%h, required %h",
                             log_q[1+k].addr, 32'h40 + 32'(4 * k));
                end
            end
            n_checks++;
            if (log_q[10].gap != 1 || log_q[11].gap != RG + 1 || log_q[12].gap != RG + 1) begin
                n_fail++;
                $display("FAIL happy_poll_gap: got %0d %0d %0d, required 1 %0d %0d",
                         log_q[10].gap, log_q[11].gap, log_q[12].gap, RG + 1, RG + 1);
            end
        end
    endtask

    task automatic test_acq_retry();
        logic [N*32-1:0] regs;
        bit ok;
        regs = rand_regs();
        log_q.delete();
        push_rd(32'h4, 32'hFFFF_FFFF);
        push_rd(32'h4, 32'hFFFF_FFFF);
        push_rd(32'h4, 32'h1);
        push_writes_trig(regs);
        push_rd(32'hC, 32'h0);
        push_rd(32'h1004, 32'h1234_5678);
        start_job(regs);
        wait_done(ok);
        if (ok) begin
            n_checks++;
            if (done_ctx_o !== 8'h1 || done_cnt_o !== 32'h1234_5678 || done_err_o !== 1'b0) begin
                n_fail++;
                $display("FAIL acq_done: got ctx=%h cnt=%h err=%b, required 01 12345678 0",
                         done_ctx_o, done_cnt_o, done_err_o);
            end
        end
        @(negedge clk_i);
        n_checks++;
        if (count_addr(32'h4) != 3 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL acq_count: got acq=%0d left=%0d, required 3 0", count_addr(32'h4), exp_q.size());
        end
        if (log_q.size() >= 3) begin
            n_checks++;
            if (log_q[1].gap != RG + 1 || log_q[2].gap != RG + 1) begin
                n_fail++;
                $display("FAIL acq_gap: got %0d %0d, required %0d %0d",
                         log_q[1].gap, log_q[2].gap, RG + 1, RG + 1);
            end
        end
    endtask

    task automatic test_gnt_delay();
        logic [N*32-1:0] regs;
        bit ok;
        int h;
        regs = rand_regs();
        log_q.delete();
        dly_addr   = 32'h54;
        dly_cycles = 3;
        push_rd(32'h4, 32'h3);
        push_writes_trig(regs);
        push_rd(32'hC, 32'h0);
        push_rd(32'h1004, 32'h55);
        start_job(regs);
        wait_done(ok);
        @(negedge clk_i);
        dly_addr   = 32'hFFFF_FFFF;
        dly_cycles = 0;
        h = -1;
        foreach (log_q[i]) if (log_q[i].addr == 32'h54) h = log_q[i].hold;
        n_checks++;
        if (count_addr(32'h54) != 1 || h != 4) begin
            n_fail++;
            $display("FAIL gnt_delay: got writes=%0d hold=%0d, required 1 4", count_addr(32'h54), h);
        end
        n_checks++;
        if (exp_q.size() != 0 || done_cnt_o !== 32'h55 || done_ctx_o !== 8'h3) begin
            n_fail++;
            $display("FAIL gnt_delay_done: got left=%0d cnt=%h ctx=%h, required 0 00000055 03",
                     exp_q.size(), done_cnt_o, done_ctx_o);
        end
    endtask

    task automatic test_timeout();
        logic [N*32-1:0] regs;
        bit ok;
        regs = rand_regs();
        log_q.delete();
        push_rd(32'h4, 32'h7);
        push_writes_trig(regs);
        for (int i = 0; i < TO; i++) push_rd(32'hC, 32'h1);
        start_job(regs);
        wait_done(ok);
        if (ok) begin
            n_checks++;
            if (done_err_o !== 1'b1 || done_cnt_o !== 32'h0 || done_ctx_o !== 8'h7) begin
                n_fail++;
                $display("FAIL timeout_done: got err=%b cnt=%h ctx=%h, required 1 00000000 07",
                         done_err_o, done_cnt_o, done_ctx_o);
            end
        end
        repeat (10) @(negedge clk_i);
        n_checks++;
        if (count_addr(32'hC) != TO || count_addr(32'h1004) != 0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL timeout_count: got status=%0d dbg=%0d left=%0d, required %0d 0 0",
                     count_addr(32'hC), count_addr(32'h1004), exp_q.size(), TO);
        end
    endtask

    task automatic test_done_hold();
        logic [N*32-1:0] regs;
        bit ok;
        regs = rand_regs();
        log_q.delete();
        done_ready_i = 1'b0;
        push_rd(32'h4, 32'h5);
        push_writes_trig(regs);
        push_rd(32'hC, 32'h0);
        push_rd(32'h1004, 32'hABCD);
        start_job(regs);
        wait_done(ok);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (done_valid_o !== 1'b1 || done_ctx_o !== 8'h5 || done_cnt_o !== 32'hABCD ||
                done_err_o !== 1'b0 || job_ready_o !== 1'b0) begin
                n_fail++;
                $display("FAIL done_hold: got valid=%b ctx=%h cnt=%h err=%b job_ready=%b, required 1 05 0000abcd 0 0",
                         done_valid_o, done_ctx_o, done_cnt_o, done_err_o, job_ready_o);
            end
            job_valid_i = 1'b1;
            @(negedge clk_i);
        end
        job_valid_i  = 1'b0;
        done_ready_i = 1'b1;
        @(negedge clk_i);
        n_checks++;
        if (done_valid_o !== 1'b0 || job_ready_o !== 1'b1 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL done_release: got valid=%b job_ready=%b left=%0d, required 0 1 0",
                     done_valid_o, job_ready_o, exp_q.size());
        end
    endtask

    task automatic test_reset_midjob();
        logic [N*32-1:0] regs;
        bit ok;
        bit found;
        regs = rand_regs();
        log_q.delete();
        push_rd(32'h4, 32'h0);
        push_writes_trig(regs);
        start_job(regs);
        found = 1'b0;
        for (int i = 0; i < 500 && !found; i++) begin
            @(negedge clk_i);
            if (periph_req_o && periph_add_o == 32'h4C) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL midjob_reach: got no write to 0000004c, required one");
        end
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        n_checks++;
        if (periph_req_o !== 1'b0 || job_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL midjob_reset: got req=%b job_ready=%b, required 0 1", periph_req_o, job_ready_o);
        end
        repeat (3) @(negedge clk_i);
        n_checks++;
        if (periph_req_o !== 1'b0 || job_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL midjob_idle: got req=%b job_ready=%b, required 0 1", periph_req_o, job_ready_o);
        end
        exp_q.delete();
        log_q.delete();
        regs = rand_regs();
        push_rd(32'h4, 32'h2);
        push_writes_trig(regs);
        push_rd(32'hC, 32'h0);
        push_rd(32'h1004, 32'h77);
        start_job(regs);
        wait_done(ok);
        @(negedge clk_i);
        n_checks++;
        if (log_q.size() == 0 || log_q[0].addr !== 32'h4 || done_ctx_o !== 8'h2 ||
            done_cnt_o !== 32'h77 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL midjob_restart: got txns=%0d ctx=%h cnt=%h left=%0d, required first=00000004 02 00000077 0",
                     log_q.size(), done_ctx_o, done_cnt_o, exp_q.size());
        end
    endtask

    initial begin
        rst_i        = 1'b1;
        job_valid_i  = 1'b0;
        job_regs_i   = '0;
        done_ready_i = 1'b1;
        test_reset();
        test_happy();
        $display("happy path done: checks=%0d", n_checks);
        test_acq_retry();
        $display("acquire retry done: checks=%0d", n_checks);
        test_gnt_delay();
        $display("grant delay done: checks=%0d", n_checks);
        test_timeout();
        $display("poll timeout done: checks=%0d", n_checks);
        test_done_hold();
        $display("done hold done: checks=%0d", n_checks);
        test_reset_midjob();
        $display("mid-job reset done: checks=%0d", n_checks);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation still running at 2 ms, required finish");
        $fatal(1, "global timeout");
    end

endmodule
